seg7_scan_driver: RTL and testbench

- Downstream display stage for the stopwatch. Consumes the six BCD digits (hr_h, hr_l, min_h, min_l, sec_h, sec_l) and drives a time-multiplexed 6-digit common-anode 7-segment display.
- Contains the scan divider, frame-coherent digit snapshot, BCD-to-segment decode, inter-digit blanking, leading-zero suppression and whole-display blink.

---
 rtl/seg7_scan_driver_if.sv | 29 ++
 rtl/seg7_scan_driver.sv | 139 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Purpose: stopwatch digit inputs and multiplexed display outputs, bundled as one bus.
// Latency: no logic here; the driver registers every output.
// Backpressure: none; the digits are sampled as levels and the display outputs are free-running.
interface seg7_scan_driver_if;
    logic [3:0] hr_h;
    logic [3:0] hr_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
    logic       blank_lz;
    logic       blink_en;
    logic [5:0] dig_sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    // Digit source and display consumer side
    modport master (
        output hr_h, hr_l, min_h, min_l, sec_h, sec_l, blank_lz, blink_en,
        input  dig_sel, seg, dp, frame_done
    );

    // Scan driver side
    modport slave (
        input  hr_h, hr_l, min_h, min_l, sec_h, sec_l, blank_lz, blink_en,
        output dig_sel, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose: 6-digit common-anode scan driver: frame snapshot, BCD decode, blanking, LZ suppress, blink.
// Latency: outputs are registered from next-state, so they describe the current slot and count.
// Backpressure: none; the inputs are sampled once per frame and the scan always runs.
module seg7_scan_driver #(
    parameter int CLK_DIV      = 1000,
    parameter int BLANK_CYC    = 2,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               Clk,
    input  logic               rst_n,
    seg7_scan_driver_if.slave  bus
);
    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] BLANK_V = DW'(BLANK_CYC);
    localparam logic [FW-1:0] FR_MAX  = FW'(BLINK_FRAMES - 1);

    logic [DW-1:0]   r_div_cnt;
    logic [2:0]      r_slot;
    logic [5:0][3:0] r_sh;        // index 5 = hr_h ... 0 = sec_l, same as the slot number
    logic [FW-1:0]   r_frame_cnt;
    logic            r_phase;     // 1 = blink-dark
    logic [5:0]      r_dig_sel;
    logic [6:0]      r_seg;
    logic            r_dp;
    logic            r_frame_done;

    logic            w_tick;
    logic            w_snap;
    logic [DW-1:0]   w_div_nxt;
    logic [2:0]      w_slot_nxt;
    logic [5:0][3:0] w_sh_nxt;
    logic [FW-1:0]   w_frame_nxt;
    logic            w_phase_nxt;
    logic [3:0]      w_digit;
    logic            w_lz;
    logic            w_on;
    logic [5:0]      w_dig_sel;
    logic [6:0]      w_seg;
    logic            w_dp;

    // BCD to active-low segments (bit order g..a); non-BCD codes show a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Next scan position, snapshot and blink state
    always_comb begin
        w_tick      = (r_div_cnt == DIV_MAX);
        w_snap      = w_tick && (r_slot == 3'd5);
        w_div_nxt   = w_tick ? '0 : r_div_cnt + DW'(1);
        w_slot_nxt  = r_slot;
        if (w_tick) begin
            w_slot_nxt = (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        end
        w_sh_nxt = r_sh;
        if (w_snap) begin
            w_sh_nxt = {bus.hr_h, bus.hr_l, bus.min_h, bus.min_l, bus.sec_h, bus.sec_l};
        end
        w_frame_nxt = r_frame_cnt;
        w_phase_nxt = r_phase;
        if (!bus.blink_en) begin
            w_frame_nxt = '0;
            w_phase_nxt = 1'b0;
        end else if (w_snap) begin
            if (r_frame_cnt == FR_MAX) begin
                w_frame_nxt = '0;
                w_phase_nxt = ~r_phase;
            end else begin
                w_frame_nxt = r_frame_cnt + FW'(1);
            end
        end
    end

    // Display image for the next cycle's slot, built from the next-state values
    always_comb begin
        w_digit   = w_sh_nxt[w_slot_nxt];
        w_lz      = (w_slot_nxt == 3'd5) && bus.blank_lz && (w_sh_nxt[5] == 4'd0);
        w_on      = (w_div_nxt >= BLANK_V) && !w_phase_nxt && !w_lz;
        w_dig_sel = 6'b111111;
        if (w_on) begin
            w_dig_sel[w_slot_nxt] = 1'b0;
        end
        w_dp  = !(w_on && ((w_slot_nxt == 3'd2) || (w_slot_nxt == 3'd4)));
        w_seg = f_decode(w_digit);
    end

    // Scan, snapshot and blink state registers
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_slot      <= 3'd0;
            r_sh        <= '0;
            r_frame_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_div_cnt   <= w_div_nxt;
            r_slot      <= w_slot_nxt;
            r_sh        <= w_sh_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    // Output registers; frame_done marks the first cycle showing a fresh snapshot
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_sel    <= 6'b111111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_dig_sel    <= w_dig_sel;
            r_seg        <= w_seg;
            r_dp         <= w_dp;
            r_frame_done <= w_snap;
        end
    end

    assign bus.dig_sel    = r_dig_sel;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: directed plus random checks of seg7_scan_driver against a cycle-indexed reference model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: none; the bench drives levels only.
module tb_seg7_scan_driver;
    localparam int CD = 4;
    localparam int BC = 1;
    localparam int BF = 2;
    localparam int FRAME = CD * 6;

    logic Clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clk = ~Clk;

    seg7_scan_driver_if sv_if ();

    seg7_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
        .Clk   (Clk),
        .rst_n (rst_n),
        .bus   (sv_if.slave)
    );

    logic [6:0] SEGT [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
                              7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111};

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: cycle index since reset release, shown digits, frames seen while blinking
    int         m_t;
    logic [3:0] m_sh [6];
    int         m_nf;
    logic [5:0] e_dig;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_fd;

    task automatic m_reset();
        m_t = 0;
        m_nf = 0;
        for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        e_dig = 6'b111111;
        e_seg = 7'b1111111;
        e_dp  = 1'b1;
        e_fd  = 1'b0;
    endtask

    // Cycle c: slot = (c / CD) % 6, position in slot = c % CD; a new sample is shown from c % FRAME == 0
    task automatic model_step();
        int c, slot, div;
        bit snap, dark, lz, on;
        if (!rst_n) begin
            m_reset();
            return;
        end
        m_t++;
        c = m_t;
        snap = (c % FRAME) == 0;
        if (snap) begin
            m_sh[0] = sv_if.sec_l;
            m_sh[1] = sv_if.sec_h;
            m_sh[2] = sv_if.min_l;
            m_sh[3] = sv_if.min_h;
            m_sh[4] = sv_if.hr_l;
            m_sh[5] = sv_if.hr_h;
        end
        if (!sv_if.blink_en) m_nf = 0;
        else if (snap) m_nf++;
        div  = c % CD;
        slot = (c / CD) % 6;
        dark = ((m_nf / BF) % 2) == 1;
        lz   = (slot == 5) && sv_if.blank_lz && (m_sh[5] == 4'd0);
        on   = (div >= BC) && !dark && !lz;
        e_dig = 6'b111111;
        if (on) e_dig[slot] = 1'b0;
        e_seg = SEGT[m_sh[slot]];
        e_dp  = (on && (slot == 2 || slot == 4)) ? 1'b0 : 1'b1;
        e_fd  = snap;
    endtask

    task automatic check_outputs();
        n_cmp++;
        assert (sv_if.dig_sel === e_dig) else begin
            n_fail++;
            $error("FAIL dig_sel t=%0d got %b want %b", m_t, sv_if.dig_sel, e_dig);
        end
        n_cmp++;
        assert (sv_if.seg === e_seg) else begin
            n_fail++;
            $error("FAIL seg t=%0d got %b want %b", m_t, sv_if.seg, e_seg);
        end
        n_cmp++;
        assert (sv_if.dp === e_dp) else begin
            n_fail++;
            $error("FAIL dp t=%0d got %b want %b", m_t, sv_if.dp, e_dp);
        end
        n_cmp++;
        assert (sv_if.frame_done === e_fd) else begin
            n_fail++;
            $error("FAIL frame_done t=%0d got %b want %b", m_t, sv_if.frame_done, e_fd);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_digits(input logic [3:0] h1, h0, m1, m0, s1, s0);
        sv_if.hr_h = h1; sv_if.hr_l = h0; sv_if.min_h = m1;
        sv_if.min_l = m0; sv_if.sec_h = s1; sv_if.sec_l = s0;
    endtask

    initial begin
        int first_fd;
        bit found;

        // Reset held with the clock running
        set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9);
        sv_if.blank_lz = 1'b0;
        sv_if.blink_en = 1'b0;
        m_reset();
        run(3);
        rst_n = 1'b1;
        #1;
        check_outputs();

        // First frame shows zeros; first frame_done 24 clocks after release
        first_fd = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (sv_if.frame_done && first_fd < 0) first_fd = k;
        end
        n_cmp++;
        assert (first_fd === FRAME) else begin
            n_fail++;
            $error("FAIL first_frame_done got %0d want %0d", first_fd, FRAME);
        end

        // Normal frame, then sec_l changed during slot 2
        run(FRAME - 6 + 10);
        sv_if.sec_l = 4'd3;
        run(2 * FRAME);

        // Leading-zero suppression variants
        sv_if.hr_h = 4'd0; sv_if.blank_lz = 1'b1;
        run(2 * FRAME);
        sv_if.blank_lz = 1'b0;
        run(2 * FRAME);
        sv_if.hr_h = 4'd1; sv_if.blank_lz = 1'b1;
        run(2 * FRAME);

        // Blink: two lit frames, two dark frames, repeating
        sv_if.blink_en = 1'b1;
        run(5 * FRAME);
        found = 0;
        for (int k = 0; k < 10 * FRAME && !found; k++) begin
            tick();
            if (((m_nf / BF) % 2) == 1 && (m_t % CD) == 1 && ((m_t / CD) % 6) != 5) found = 1;
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL blink_dark_reached got %0d want 1", found);
        end
        sv_if.blink_en = 1'b0;
        tick();
        n_cmp++;
        assert (sv_if.dig_sel !== 6'b111111) else begin
            n_fail++;
            $error("FAIL blink_release got %b want one digit low", sv_if.dig_sel);
        end
        run(FRAME);

        // Invalid BCD on min_l shows a dash in slot 2
        sv_if.min_l = 4'hC;
        run(2 * FRAME);
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            tick();
            if ((m_t % CD) == 1 && ((m_t / CD) % 6) == 2) found = 1;
        end
        n_cmp++;
        assert (found && sv_if.seg === 7'b0111111) else begin
            n_fail++;
            $error("FAIL dash_slot2 got %b want %b", sv_if.seg, 7'b0111111);
        end

        // Reset pulse in the middle of slot 3
        found = 0;
        for (int k = 0; k < 2 * FRAME && !found; k++) begin
            tick();
            if ((m_t % CD) == 1 && ((m_t / CD) % 6) == 3) found = 1;
        end
        n_cmp++;
        assert (found) else begin
            n_fail++;
            $error("FAIL slot3_reached got %0d want 1", found);
        end
        rst_n = 1'b0;
        m_reset();
        #1;
        check_outputs();
        run(2);
        rst_n = 1'b1;
        #1;
        check_outputs();
        run(2 * FRAME);

        // Random digits and control toggles
        for (int k = 0; k < 600; k++) begin
            tick();
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 5))
                    0: sv_if.sec_l = 4'($urandom_range(0, 15));
                    1: sv_if.sec_h = 4'($urandom_range(0, 15));
                    2: sv_if.min_l = 4'($urandom_range(0, 15));
                    3: sv_if.min_h = 4'($urandom_range(0, 15));
                    4: sv_if.hr_l  = 4'($urandom_range(0, 15));
                    default: sv_if.hr_h = 4'($urandom_range(0, 2));
                endcase
            end
            if ($urandom_range(0, 79) == 0) sv_if.blink_en = ~sv_if.blink_en;
            if ($urandom_range(0, 49) == 0) sv_if.blank_lz = ~sv_if.blank_lz;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
